// File: rtl/skeleton_seq_pkg.sv
// Shared state encoding and default widths for the skeleton filter sequencer.
package skeleton_seq_pkg;

  localparam int DEF_BITWIDTH_SYS = 16;
  localparam int DEF_BITWIDTH_CNT = 16;
  localparam int DEF_BITWIDTH_TMO = 8;
  localparam int DEF_TIMEOUT_CYC  = 200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_TRIG   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PUSH   = 3'd4,
    ST_FINISH = 3'd5
  } seq_state_t;

endpackage

// File: rtl/skeleton_seq_timeout.sv
// Per-sample timeout counter: cleared on trigger, counts waiting cycles,
// flags the enabled cycle in which the count reaches TIMEOUT_CYC.
module skeleton_seq_timeout
  import skeleton_seq_pkg::*;
#(
  parameter int BITWIDTH_TMO = DEF_BITWIDTH_TMO,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic reached
);

  // Count value just before the final waiting cycle.
  localparam logic [BITWIDTH_TMO-1:0] LAST = BITWIDTH_TMO'(TIMEOUT_CYC - 1);

  logic [BITWIDTH_TMO-1:0] cnt_q;
  logic [BITWIDTH_TMO-1:0] cnt_d;

  assign reached = en && (cnt_q == LAST);

  // Next count: clear wins over enable, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + BITWIDTH_TMO'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/skeleton_filter_sequencer.sv
// Burst controller feeding one filter skeleton: fetch a sample, trigger the
// skeleton, wait for its ready edge, push the result, repeat NUM_SAMPLES times.
module skeleton_filter_sequencer
  import skeleton_seq_pkg::*;
#(
  parameter int BITWIDTH_SYS = DEF_BITWIDTH_SYS,
  parameter int BITWIDTH_CNT = DEF_BITWIDTH_CNT,
  parameter int BITWIDTH_TMO = DEF_BITWIDTH_TMO,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic                    CLK_SYS,
  input  logic                    RST,
  input  logic                    START,
  input  logic [BITWIDTH_CNT-1:0] NUM_SAMPLES,
  input  logic [BITWIDTH_SYS-1:0] S_DATA,
  input  logic                    S_VALID,
  output logic                    S_READY,
  output logic [BITWIDTH_SYS-1:0] M_DATA,
  output logic                    M_VALID,
  input  logic                    M_READY,
  output logic                    DUT_EN,
  output logic                    DUT_TRGG,
  output logic [BITWIDTH_SYS-1:0] DUT_DATA_IN,
  input  logic [BITWIDTH_SYS-1:0] DUT_DATA_OUT,
  input  logic                    DUT_RDY,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR_TIMEOUT,
  output logic [BITWIDTH_CNT-1:0] CNT_DONE
);

  seq_state_t              state_q, state_d;
  logic [BITWIDTH_CNT-1:0] num_q, num_d;
  logic [BITWIDTH_CNT-1:0] cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [BITWIDTH_SYS-1:0] din_q, din_d;
  logic [BITWIDTH_SYS-1:0] mdata_q, mdata_d;
  logic                    rdy_q, rdy_d;

  logic                    rdy_edge;
  logic                    tmo_clr;
  logic                    tmo_en;
  logic                    tmo_reached;
  logic [BITWIDTH_CNT-1:0] cnt_inc;

  // Ready is a level from the skeleton; only a fresh rise completes a sample.
  assign rdy_edge = DUT_RDY && !rdy_q;
  assign cnt_inc  = cnt_q + BITWIDTH_CNT'(1);
  assign tmo_clr  = (state_q == ST_TRIG);
  assign tmo_en   = (state_q == ST_WAIT) && !rdy_edge;

  skeleton_seq_timeout #(
    .BITWIDTH_TMO (BITWIDTH_TMO),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (CLK_SYS),
    .rst     (RST),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .reached (tmo_reached)
  );

  assign S_READY     = (state_q == ST_FETCH);
  assign DUT_TRGG    = (state_q == ST_TRIG);
  assign M_VALID     = (state_q == ST_PUSH);
  assign DONE        = (state_q == ST_FINISH);
  assign BUSY        = (state_q != ST_IDLE);
  assign DUT_EN      = BUSY;
  assign ERR_TIMEOUT = err_q;
  assign CNT_DONE    = cnt_q;
  assign DUT_DATA_IN = din_q;
  assign M_DATA      = mdata_q;

  // Next-state and data-capture logic for the burst sequence.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    din_d   = din_q;
    mdata_d = mdata_q;
    rdy_d   = DUT_RDY;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          num_d   = NUM_SAMPLES;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (NUM_SAMPLES == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (S_VALID) begin
          din_d   = S_DATA;
          state_d = ST_TRIG;
        end
      end
      ST_TRIG: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rdy_edge) begin
          mdata_d = DUT_DATA_OUT;
          state_d = ST_PUSH;
        end else if (tmo_reached) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_PUSH: begin
        if (M_READY) begin
          cnt_d   = cnt_inc;
          // Compare against the latched length so the count never wraps.
          state_d = (cnt_inc == num_q) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, control and data registers; everything clears on reset.
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      din_q   <= '0;
      mdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      din_q   <= din_d;
      mdata_q <= mdata_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_skeleton_filter_sequencer.sv
// Bench for skeleton_filter_sequencer: host stream driver, a behavioural
// filter-skeleton model, and a per-cycle protocol/timing reference model.
module tb_skeleton_filter_sequencer;

  localparam int TMO = 200;

  logic        CLK_SYS;
  logic        RST;
  logic        START;
  logic [15:0] NUM_SAMPLES;
  logic [15:0] S_DATA;
  logic        S_VALID;
  logic        S_READY;
  logic [15:0] M_DATA;
  logic        M_VALID;
  logic        M_READY;
  logic        DUT_EN;
  logic        DUT_TRGG;
  logic [15:0] DUT_DATA_IN;
  logic [15:0] DUT_DATA_OUT;
  logic        DUT_RDY;
  logic        BUSY;
  logic        DONE;
  logic        ERR_TIMEOUT;
  logic [15:0] CNT_DONE;

  skeleton_filter_sequencer #(
    .BITWIDTH_SYS (16),
    .BITWIDTH_CNT (16),
    .BITWIDTH_TMO (8),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .CLK_SYS      (CLK_SYS),
    .RST          (RST),
    .START        (START),
    .NUM_SAMPLES  (NUM_SAMPLES),
    .S_DATA       (S_DATA),
    .S_VALID      (S_VALID),
    .S_READY      (S_READY),
    .M_DATA       (M_DATA),
    .M_VALID      (M_VALID),
    .M_READY      (M_READY),
    .DUT_EN       (DUT_EN),
    .DUT_TRGG     (DUT_TRGG),
    .DUT_DATA_IN  (DUT_DATA_IN),
    .DUT_DATA_OUT (DUT_DATA_OUT),
    .DUT_RDY      (DUT_RDY),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERR_TIMEOUT  (ERR_TIMEOUT),
    .CNT_DONE     (CNT_DONE)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus controls shared with the driver processes.
  int          lat_q[$];     // per-sample skeleton latency; -1 never ready, -2 ready already high
  logic [15:0] sdata_q[$];   // forced sample values, random otherwise
  int          sv_pct = 100;
  int          mr_pct = 100;
  int          stall_res  = -1;
  int          stall_left = 0;

  // Observations of the current burst.
  int          res_idx = 0;
  int          done_pulses = 0;
  int          sready_cycles = 0;
  int          trgg_cycles = 0;
  int          last_trgg_cyc = 0;
  int          last_done_cyc = 0;
  int          start_cyc = 0;
  int          stall_seen = 0;
  int          lat_obs[$];
  logic [15:0] got_res[$];
  logic [15:0] sent_q[$];
  logic        mv_prev = 1'b0;

  // Reference model expectations for the current cycle.
  logic        m_busy = 0, m_sready = 0, m_trgg = 0, m_mvalid = 0, m_done = 0, m_err = 0;
  logic        m_waiting = 0, m_rdy_prev = 0;
  logic [15:0] m_cnt = 0, m_n = 0, m_mdata = 0, m_din = 0;
  int          m_wait = 0;
  logic        n_busy, n_sready, n_trgg, n_mvalid, n_done, n_err, n_waiting;
  logic [15:0] n_cnt, n_n, n_mdata, n_din;
  int          n_wait;

  function automatic logic [15:0] skel_f(input logic [15:0] x);
    return {x[7:0], x[15:8]} + 16'h0101;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    CLK_SYS = 1'b0;
    forever #5 CLK_SYS = ~CLK_SYS;
  end

  initial begin
    forever begin
      @(posedge CLK_SYS);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // Host side: sample source and result sink.
  initial begin
    S_VALID = 1'b0;
    S_DATA  = '0;
    M_READY = 1'b0;
    forever begin
      @(posedge CLK_SYS);
      #1;
      S_VALID = (int'($urandom_range(99)) < sv_pct);
      S_DATA  = (sdata_q.size() > 0) ? sdata_q[0] : 16'($urandom);
      M_READY = (stall_res == res_idx && stall_left > 0) ? 1'b0
              : (int'($urandom_range(99)) < mr_pct);
    end
  end

  // Filter skeleton model: computes skel_f of the triggered sample and raises
  // its ready level after a configurable latency.
  initial begin
    int          lat;
    logic [15:0] x;
    DUT_RDY      = 1'b0;
    DUT_DATA_OUT = '0;
    forever begin
      @(negedge CLK_SYS);
      if (!RST && S_VALID && S_READY) begin
        lat = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(6, 1));
        @(posedge CLK_SYS);
        #1;
        if (lat == -2) begin
          DUT_RDY      = 1'b1;
          DUT_DATA_OUT = 16'hDEAD;
        end else begin
          DUT_RDY = 1'b0;
        end
        @(negedge CLK_SYS);
        x = DUT_DATA_IN;
        if (lat == -2) begin
          @(posedge CLK_SYS);
          #1;
          @(posedge CLK_SYS);
          #1;
          DUT_RDY = 1'b0;
          @(posedge CLK_SYS);
          #1;
          DUT_RDY      = 1'b1;
          DUT_DATA_OUT = skel_f(x);
        end else if (lat > 0) begin
          repeat (lat) @(posedge CLK_SYS);
          #1;
          DUT_RDY      = 1'b1;
          DUT_DATA_OUT = skel_f(x);
        end
      end
    end
  end

  // Compare process: checks every output each cycle against the reference
  // model, scoreboards results end to end, then advances the model.
  initial begin
    forever begin
      @(negedge CLK_SYS);
      if (RST) begin
        check("reset_outputs",
              {S_READY, M_VALID, DUT_EN, DUT_TRGG, BUSY, DONE, ERR_TIMEOUT, CNT_DONE, M_DATA, DUT_DATA_IN},
              64'd0);
        m_busy = 0; m_sready = 0; m_trgg = 0; m_mvalid = 0; m_done = 0; m_err = 0;
        m_waiting = 0; m_rdy_prev = 0; m_cnt = 0; m_n = 0; m_mdata = 0; m_din = 0; m_wait = 0;
        sent_q.delete();
        mv_prev = 1'b0;
      end else begin
        check("busy",        BUSY,        m_busy);
        check("dut_en",      DUT_EN,      m_busy);
        check("s_ready",     S_READY,     m_sready);
        check("dut_trgg",    DUT_TRGG,    m_trgg);
        check("m_valid",     M_VALID,     m_mvalid);
        check("done",        DONE,        m_done);
        check("err_timeout", ERR_TIMEOUT, m_err);
        check("cnt_done",    CNT_DONE,    m_cnt);
        if (m_mvalid) check("m_data", M_DATA, m_mdata);
        if (m_trgg)   check("dut_data_in", DUT_DATA_IN, m_din);

        // Burst observations.
        if (S_VALID && S_READY) begin
          sent_q.push_back(S_DATA);
          if (sdata_q.size() > 0) void'(sdata_q.pop_front());
        end
        if (S_READY) sready_cycles++;
        if (DUT_TRGG) begin
          trgg_cycles++;
          last_trgg_cyc = cyc;
        end
        if (M_VALID && !mv_prev) lat_obs.push_back(cyc - last_trgg_cyc);
        mv_prev = M_VALID;
        if (M_VALID && stall_res == res_idx) begin
          if (stall_left > 0) stall_left--;
          if (M_DATA == 16'h1234) stall_seen++;
        end
        if (M_VALID && M_READY) begin
          got_res.push_back(M_DATA);
          if (sent_q.size() > 0) check("e2e_data", M_DATA, skel_f(sent_q.pop_front()));
          else check("e2e_sample_present", 0, 1);
          res_idx++;
        end
        if (DONE) begin
          done_pulses++;
          last_done_cyc = cyc;
        end

        // Advance the reference model by one cycle.
        n_busy = m_busy; n_sready = m_sready; n_trgg = 1'b0; n_mvalid = m_mvalid;
        n_done = 1'b0; n_err = m_err; n_waiting = m_waiting; n_cnt = m_cnt; n_n = m_n;
        n_mdata = m_mdata; n_din = m_din; n_wait = m_wait;
        if (!m_busy && START) begin
          n_n = NUM_SAMPLES; n_cnt = 0; n_err = 1'b0; n_busy = 1'b1;
          if (NUM_SAMPLES == 0) n_done = 1'b1;
          else n_sready = 1'b1;
          sent_q.delete();
        end
        if (m_done) n_busy = 1'b0;
        if (m_sready && S_VALID) begin
          n_sready = 1'b0; n_din = S_DATA; n_trgg = 1'b1;
        end
        if (m_trgg) begin
          n_waiting = 1'b1; n_wait = 0;
        end
        if (m_waiting) begin
          if (DUT_RDY && !m_rdy_prev) begin
            n_waiting = 1'b0; n_mdata = DUT_DATA_OUT; n_mvalid = 1'b1;
          end else begin
            n_wait = m_wait + 1;
            if (n_wait == TMO) begin
              n_waiting = 1'b0; n_err = 1'b1; n_done = 1'b1;
            end
          end
        end
        if (m_mvalid && M_READY) begin
          n_mvalid = 1'b0; n_cnt = m_cnt + 16'd1;
          if (n_cnt == m_n) n_done = 1'b1;
          else n_sready = 1'b1;
        end
        m_busy = n_busy; m_sready = n_sready; m_trgg = n_trgg; m_mvalid = n_mvalid;
        m_done = n_done; m_err = n_err; m_waiting = n_waiting; m_cnt = n_cnt; m_n = n_n;
        m_mdata = n_mdata; m_din = n_din; m_wait = n_wait;
        m_rdy_prev = DUT_RDY;
      end
    end
  end

  task automatic clear_obs();
    res_idx = 0; done_pulses = 0; sready_cycles = 0; trgg_cycles = 0; stall_seen = 0;
    lat_obs.delete();
    got_res.delete();
  endtask

  task automatic start_burst(input int n);
    @(posedge CLK_SYS);
    #1;
    START       = 1'b1;
    NUM_SAMPLES = 16'(n);
    start_cyc   = cyc;
    @(posedge CLK_SYS);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (k < budget) begin
      @(negedge CLK_SYS);
      if (DONE) break;
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s_done_wait: no DONE within %0d cycles", name, budget);
    end
    @(negedge CLK_SYS);
    @(negedge CLK_SYS);
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    NUM_SAMPLES = '0;
    repeat (3) @(posedge CLK_SYS);
    @(negedge CLK_SYS);
    check("reset_busy", BUSY, 0);
    @(posedge CLK_SYS);
    #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK_SYS);

    // Four samples, fixed 3-cycle skeleton latency, no back-pressure.
    clear_obs();
    lat_q = '{3, 3, 3, 3};
    sdata_q = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    start_burst(4);
    wait_done(100, "basic");
    check("basic_cnt", CNT_DONE, 4);
    check("basic_res_count", got_res.size(), 4);
    check("basic_res0", got_res[0], 16'h0302);
    check("basic_res1", got_res[1], 16'h0504);
    check("basic_res2", got_res[2], 16'h0706);
    check("basic_res3", got_res[3], 16'h0908);
    check("basic_done_pulses", done_pulses, 1);
    check("basic_err", ERR_TIMEOUT, 0);
    check("basic_done_cycle", last_done_cyc - start_cyc, 25);
    check("basic_result_latency", lat_obs[0], 4);

    // Zero-length burst.
    clear_obs();
    start_burst(0);
    wait_done(10, "zero");
    check("zero_done_cycle", last_done_cyc - start_cyc, 1);
    check("zero_sready", sready_cycles, 0);
    check("zero_trgg", trgg_cycles, 0);
    check("zero_cnt", CNT_DONE, 0);

    // START held through the DONE cycle is not taken again.
    clear_obs();
    @(posedge CLK_SYS);
    #1;
    START = 1'b1; NUM_SAMPLES = 16'd0;
    repeat (2) @(posedge CLK_SYS);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK_SYS);
    check("start_on_done_pulses", done_pulses, 1);

    // Timeout on the second of three samples, then recovery.
    clear_obs();
    lat_q = '{3, -1};
    start_burst(3);
    wait_done(400, "timeout");
    check("timeout_err", ERR_TIMEOUT, 1);
    check("timeout_cnt", CNT_DONE, 1);
    check("timeout_done_pulses", done_pulses, 1);
    check("timeout_wait_len", last_done_cyc - last_trgg_cyc, TMO + 1);
    clear_obs();
    start_burst(1);
    check("err_cleared", ERR_TIMEOUT, 0);
    wait_done(100, "recover");
    check("recover_cnt", CNT_DONE, 1);
    check("recover_err", ERR_TIMEOUT, 0);

    // Back-pressure on result 1.
    clear_obs();
    lat_q = '{2, 2, 2};
    sdata_q = '{16'h1111, 16'h3311, 16'h2222};
    stall_res = 1;
    stall_left = 10;
    start_burst(3);
    wait_done(100, "stall");
    stall_res = -1;
    check("stall_res1", got_res[1], 16'h1234);
    check("stall_held_cycles", stall_seen, 11);
    check("stall_cnt", CNT_DONE, 3);

    // START while busy, and ready already high when triggered.
    clear_obs();
    lat_q = '{-2, 2};
    sdata_q = '{16'h4455, 16'h6677};
    start_burst(2);
    repeat (2) @(posedge CLK_SYS);
    #1;
    START = 1'b1; NUM_SAMPLES = 16'd7;
    @(posedge CLK_SYS);
    #1;
    START = 1'b0;
    wait_done(100, "busy_start");
    check("busy_start_cnt", CNT_DONE, 2);
    check("busy_start_done_pulses", done_pulses, 1);
    check("prehigh_res0", got_res[0], 16'h5645);
    check("prehigh_latency", lat_obs[0], 4);
    check("second_latency", lat_obs[1], 3);

    // Reset while waiting on the skeleton, then a clean burst.
    clear_obs();
    lat_q = '{-1};
    start_burst(2);
    begin
      int k = 0;
      while (!DUT_TRGG && k < 20) begin
        @(negedge CLK_SYS);
        k++;
      end
      check("rst_reach_trig", DUT_TRGG, 1);
    end
    repeat (3) @(posedge CLK_SYS);
    #1;
    RST = 1'b1;
    @(negedge CLK_SYS);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_m_valid", M_VALID, 0);
    @(posedge CLK_SYS);
    #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK_SYS);
    check("rst_no_done", done_pulses, 0);
    clear_obs();
    lat_q.delete();
    start_burst(5);
    wait_done(200, "post_rst");
    check("post_rst_cnt", CNT_DONE, 5);
    check("post_rst_err", ERR_TIMEOUT, 0);

    // Randomized bursts with random flow control and skeleton latency.
    for (int b = 0; b < 10; b++) begin
      int n;
      n = int'($urandom_range(8, 1));
      sv_pct = int'($urandom_range(100, 40));
      mr_pct = int'($urandom_range(100, 40));
      clear_obs();
      start_burst(n);
      wait_done(600, "random");
      check("random_cnt", CNT_DONE, 64'(n));
      check("random_res_count", got_res.size(), n);
      check("random_done_pulses", done_pulses, 1);
      check("random_err", ERR_TIMEOUT, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skeleton_filter_sequencer.md
# skeleton_filter_sequencer

Burst controller that drives one filter skeleton on device. It pulls NUM_SAMPLES words from a host-side stream and feeds each to the skeleton with a one-cycle calculation trigger. It waits for the skeleton's ready, then forwards each result to an output stream. It also provides a per-sample timeout, a completed-sample counter and a done pulse for the host measurement logic.

## Interface
Parameters:
- BITWIDTH_SYS, 16, width of data bus on device (sample in/out)
- BITWIDTH_CNT, 16, width of sample counter / NUM_SAMPLES
- BITWIDTH_TMO, 8, width of timeout counter
- TIMEOUT_CYC, 200, max cycles waited for DUT_RDY rising edge per sample (1..2^BITWIDTH_TMO-1)

Ports:
- CLK_SYS  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  burst start pulse; ignored while BUSY
- NUM_SAMPLES  in  BITWIDTH_CNT  burst length, latched on accepted START
- S_DATA  in  BITWIDTH_SYS  input sample
- S_VALID  in  1  input sample valid
- S_READY  out  1  sequencer accepts sample
- M_DATA  out  BITWIDTH_SYS  filtered result
- M_VALID  out  1  result valid
- M_READY  in  1  downstream accepts result
- DUT_EN  out  1  skeleton enable
- DUT_TRGG  out  1  skeleton start-calculation pulse
- DUT_DATA_IN  out  BITWIDTH_SYS  sample to skeleton
- DUT_DATA_OUT  in  BITWIDTH_SYS  skeleton result
- DUT_RDY  in  1  skeleton result ready (level)
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle pulse at burst end (normal or timeout)
- ERR_TIMEOUT  out  1  sticky: burst aborted by timeout; cleared on next accepted START
- CNT_DONE  out  BITWIDTH_CNT  samples completed in current/last burst

## Operation
- States: IDLE, FETCH, TRIG, WAIT, PUSH, FINISH.
- IDLE: START=1 latches NUM_SAMPLES, clears CNT_DONE and ERR_TIMEOUT. Goes to FINISH if NUM_SAMPLES=0, else to FETCH.
- FETCH: S_READY=1. On S_VALID, S_DATA is registered into DUT_DATA_IN and the state goes to TRIG.
- TRIG: DUT_TRGG=1 for exactly this cycle, then WAIT. Timeout counter cleared.
- WAIT: rising edge of DUT_RDY is detected with registered rdy_q (reset 0), i.e. DUT_RDY=1 and rdy_q=0.
  - On edge: DUT_DATA_OUT is registered into M_DATA, then PUSH.
  - Otherwise the counter increments. If the counter reaches TIMEOUT_CYC, ERR_TIMEOUT is set, then FINISH.
- PUSH: M_VALID=1 and M_DATA held stable until M_READY. On handshake, CNT_DONE increments. Next state is FINISH if CNT_DONE+1 = NUM_SAMPLES, else FETCH.
- FINISH: DONE=1 for this cycle, then IDLE.
- DUT_EN=BUSY. BUSY=1 in every state except IDLE. DUT_DATA_IN and M_DATA hold their last value outside capture.
- Counter widths are unsigned. CNT_DONE never wraps: the compare uses the latched length.

## Timing
- Reset: all outputs 0, state IDLE, rdy_q 0. RST mid-burst aborts immediately, with no DONE pulse.
- START accepted at cycle 0 → FETCH and S_READY=1 at cycle 1.
- S handshake at cycle k → DUT_TRGG=1 at k+1 → WAIT from k+2.
- DUT_RDY edges coinciding with TRIG are ignored; rdy_q still updates.
- Edge seen at cycle w → M_VALID=1 at w+1.
- M handshake at cycle p → CNT_DONE updated and next state at p+1.
- FINISH cycle: DONE=1, BUSY=1. BUSY=0 from the next cycle.
- Timeout: DUT_RDY edge absent for TIMEOUT_CYC WAIT cycles → FINISH at the following cycle. CNT_DONE = samples completed before the failing one.
- START during BUSY is ignored, with no state change.
- START in the same cycle as DONE is ignored. It is accepted only in IDLE.

## Structure
- Package skeleton_seq_pkg holds:
  - state enum (IDLE=0, FETCH=1, TRIG=2, WAIT=3, PUSH=4, FINISH=5)
  - default widths
- Sub-module skeleton_seq_timeout: counter with clear/enable and reached flag, parameterised by BITWIDTH_TMO and TIMEOUT_CYC.
- Top instantiates it; FSM and data registers live in the top.

## Test plan
- NUM_SAMPLES=4, S_VALID always 1, M_READY always 1, DUT model raises RDY 3 cycles after TRGG → 4 results in order, CNT_DONE=4, one DONE pulse, ERR_TIMEOUT=0.
- NUM_SAMPLES=0 → DONE at cycle 1, no S_READY, no DUT_TRGG, CNT_DONE=0.
- DUT model never raises RDY on sample 2 of 3, TIMEOUT_CYC=200 → ERR_TIMEOUT=1, CNT_DONE=1, DONE once. The next START clears ERR_TIMEOUT.
- M_READY held low 10 cycles on sample 1 (0x1234) → M_DATA stable at 0x1234, M_VALID high throughout, no new S_READY until handshake.
- START pulsed while BUSY, and RDY already high at TRIG → ignored. Sample completes only after a fresh RDY rising edge.
- RST asserted in WAIT → next edge all outputs 0, BUSY=0, no DONE. A new burst then runs normally.
